// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - data-memory access stage with req/ack handshake and watchdog
// Optional feature macro: MEM_ALIGN_CHK_EN (odd word address reported as an error instead of word-aligned).
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  wdog_q;
    logic [7:0]  wdog_d;
    logic [15:0] rd_data_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        req_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] addr_d;
    logic [15:0] wdata_q;
    logic        align_bad;

    assign wdog_d = wdog_q + 8'd1;

`ifdef MEM_ALIGN_CHK_EN
    assign align_bad = addr[0];
    assign addr_d    = addr;
`else
    // Odd addresses are folded onto the enclosing word.
    assign align_bad = 1'b0;
    assign addr_d    = addr & 16'hFFFE;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wdog_q    <= 8'd0;
            rd_data_q <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if ((mem_read ^ mem_write) && !align_bad) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= mem_write;
                            addr_q  <= addr_d;
                            wdata_q <= wdata;
                            wdog_q  <= 8'd0;
                        end else if (!mem_read && !mem_write) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Ack wins over a watchdog expiring in the same cycle.
                    if (dmem_ack) begin
                        if (!we_q) begin
                            rd_data_q <= dmem_rdata;
                        end
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (wdog_q >= WDOG_LAST) begin
                        state_q <= ERR;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard testbench for mem_access_stage
module tb_mem_access_stage;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    typedef struct {
        logic        err;
        logic [15:0] rd;
        int          reqs;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          req_cnt = 0;
    logic [15:0] rd_model = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: request attributes while requesting, results on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_cnt = 0;
        end else begin
            if (dmem_req) begin
                req_cnt++;
                if (sb_q.size() > 0) begin
                    check("dmem_addr", 32'(dmem_addr), 32'(sb_q[0].addr));
                    check("dmem_we", 32'(dmem_we), 32'(sb_q[0].we));
                    if (sb_q[0].we) check("dmem_wdata", 32'(dmem_wdata), 32'(sb_q[0].wdata));
                end
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("err", 32'(err), 32'(mon_e.err));
                    check("rd_data", 32'(rd_data), 32'(mon_e.rd));
                    check("req_cycles", 32'(req_cnt), 32'(mon_e.reqs));
                end
                req_cnt = 0;
            end
        end
    end

    // k = req cycle in which ack is given (0 = never).
    task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input int k, input logic [15:0] rdata, input logic exp_err, input int exp_reqs,
                          input int exp_lat, input logic [15:0] exp_addr, input bit dup_start);
        exp_t e;
        int   lat;
        if (!exp_err && rd && !wr && k > 0) rd_model = rdata;
        e.err   = exp_err;
        e.rd    = rd_model;
        e.reqs  = exp_reqs;
        e.addr  = exp_addr;
        e.we    = wr;
        e.wdata = wd;
        sb_q.push_back(e);
        start     = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        lat       = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (dup_start && i == 2) begin
                start     = 1'b1;
                mem_read  = 1'b1;
                mem_write = 1'b0;
                addr      = 16'h0F00;
            end
            dmem_ack   = (i == k);
            dmem_rdata = (i == k) ? rdata : 16'h5A5A;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        @(negedge clk);
        dmem_ack = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rdv;
        int          rk;
        rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = 16'd0; wdata = 16'd0; dmem_rdata = 16'd0; dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", 32'(dmem_addr), 32'd0);
        check("rst_wdata", 32'(dmem_wdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 1, 2, 16'h0010, 0);
        check("load_beef", 32'(rd_data), 32'h0000BEEF);
        access(0, 1, 16'h0020, 16'h1234, 5, 16'h7777, 0, 5, 6, 16'h0020, 0);
        access(1, 0, 16'h0030, 16'h0000, 0, 16'h1111, 1, T, T + 1, 16'h0030, 0);
        access(1, 0, 16'h0032, 16'h0000, T, 16'hCAFE, 0, T, T + 1, 16'h0032, 0);
        access(0, 1, 16'h0034, 16'hAAAA, 0, 16'h2222, 1, T, T + 1, 16'h0034, 0);
        access(1, 1, 16'h0040, 16'h5555, 1, 16'h3333, 1, 0, 1, 16'h0040, 0);
        access(0, 0, 16'h0042, 16'h6666, 1, 16'h4444, 0, 0, 1, 16'h0042, 0);
        access(1, 0, 16'h0050, 16'h0000, 3, 16'h0B0B, 0, 3, 4, 16'h0050, 1);
        repeat (4) begin
            @(negedge clk);
            check("no_second_req", 32'(dmem_req), 32'd0);
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);

`ifdef MEM_ALIGN_CHK_EN
        access(1, 0, 16'h0011, 16'h0000, 1, 16'h0C0C, 1, 0, 1, 16'h0011, 0);
`else
        access(1, 0, 16'h0011, 16'h0000, 2, 16'h0C0C, 0, 2, 3, 16'h0010, 0);
`endif

        // Reset in the middle of a request.
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 16'h0060;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("req_before_rst", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_req", 32'(dmem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rd", 32'(rd_data), 32'd0);
        check("rst_mid_addr", 32'(dmem_addr), 32'd0);
        rd_model = 16'd0;
        rst_n = 1'b1;
        @(negedge clk);

        // Ack while idle must not disturb anything.
        dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("stray_done", 32'(done), 32'd0);
        check("stray_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        check("stray_rd", 32'(rd_data), 32'(rd_model));

        for (int n = 0; n < 5; n++) begin
            ra  = 16'($urandom) & 16'hFFFE;
            rdv = 16'($urandom);
            rk  = $urandom_range(1, 6);
            access(1, 0, ra, 16'h0000, rk, rdv, 0, rk, rk + 1, ra, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
